fetch_ctrl: RTL and testbench

Instruction-fetch controller for the pipeline front end, the other end of the PC register interface. It reads the current PC and issues a request/acknowledge read to instruction memory. On completion it writes the next PC back through the PC register's data and write-enable inputs and presents the fetched instruction to the IF/ID boundary. It handles decode stalls and branch/jump redirects, including a redirect that arrives while a memory read is outstanding.

---
 rtl/fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_fetch_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch controller between PC register, instruction memory and IF/ID
//
// Purpose: reads the current PC, issues a req/ack read to instruction memory,
// writes the next PC back and presents the fetched word to the IF/ID boundary.
// Handles decode stalls and redirects, including redirects that land while a
// read is still outstanding (the read is completed and its data dropped).
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_clk_en          global enable; all state frozen when low
//   i_pc              current PC register value
//   o_pc_next         PC register data input
//   o_pc_wr_en        PC register write enable (combinational)
//   o_imem_req        memory read request (held until ack)
//   o_imem_addr       registered request address
//   i_imem_ack        one-cycle acknowledge, i_imem_rdata valid alongside
//   i_imem_rdata      instruction word
//   i_stall           IF/ID consumer not ready
//   i_redirect        one-cycle branch/jump redirect
//   i_redirect_pc     redirect target
//   o_if_valid        presented instruction not yet consumed
//   o_if_pc           PC of presented instruction
//   o_if_instr        presented instruction
module fetch_ctrl #(
  parameter int                  P_ADDR_W = 32,
  parameter int                  P_DATA_W = 32,
  parameter logic [P_DATA_W-1:0] P_NOP    = 32'h00000013
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clk_en,
  input  logic [P_ADDR_W-1:0] i_pc,
  output logic [P_ADDR_W-1:0] o_pc_next,
  output logic                o_pc_wr_en,
  output logic                o_imem_req,
  output logic [P_ADDR_W-1:0] o_imem_addr,
  input  logic                i_imem_ack,
  input  logic [P_DATA_W-1:0] i_imem_rdata,
  input  logic                i_stall,
  input  logic                i_redirect,
  input  logic [P_ADDR_W-1:0] i_redirect_pc,
  output logic                o_if_valid,
  output logic [P_ADDR_W-1:0] o_if_pc,
  output logic [P_DATA_W-1:0] o_if_instr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_REQ,
    S_DROP
  } state_t;

  state_t state;

  logic                redirect_act;
  logic                seq_wr;
  logic [P_ADDR_W-1:0] pc_inc;

  // o_imem_addr doubles as the captured fetch address; it is held while a
  // request is outstanding, so the sequential next PC derives from it.
  assign pc_inc       = o_imem_addr + P_ADDR_W'(4);
  assign redirect_act = i_clk_en & i_redirect & (state != S_IDLE);
  // An ack accepted in REQ with no redirect is the only sequential PC update;
  // acks in DROP belong to an abandoned fetch.
  assign seq_wr       = i_clk_en & i_imem_ack & (state == S_REQ) & ~i_redirect;

  assign o_pc_wr_en = redirect_act | seq_wr;
  assign o_pc_next  = redirect_act ? i_redirect_pc :
                      seq_wr       ? pc_inc        : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_imem_req  <= 1'b0;
      o_imem_addr <= '0;
      o_if_valid  <= 1'b0;
      o_if_pc     <= '0;
      o_if_instr  <= P_NOP;
    end else if (i_clk_en) begin
      // Output slot: flush beats load beats consume.
      if (redirect_act) begin
        o_if_valid <= 1'b0;
      end else if (seq_wr) begin
        o_if_valid <= 1'b1;
        o_if_pc    <= o_imem_addr;
        o_if_instr <= i_imem_rdata;
      end else if (!i_stall) begin
        o_if_valid <= 1'b0;
      end

      case (state)
        S_IDLE: state <= S_ISSUE;
        S_ISSUE: begin
          o_imem_addr <= i_pc;
          // A redirect here leaves i_pc stale this cycle; recapture next cycle.
          if (!i_redirect && !(o_if_valid && i_stall)) begin
            state      <= S_REQ;
            o_imem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (i_imem_ack) begin
            state      <= S_ISSUE;
            o_imem_req <= 1'b0;
          end else if (i_redirect) begin
            state <= S_DROP;
          end
        end
        S_DROP: begin
          // Requests cannot be aborted: wait out the ack and discard it.
          if (i_imem_ack) begin
            state      <= S_ISSUE;
            o_imem_req <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic        pc_wr_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I0  = 32'hA000_0000;
  localparam logic [31:0] I1  = 32'hA111_1111;
  localparam logic [31:0] I2  = 32'hA222_2222;
  localparam logic [31:0] I3  = 32'hA333_3333;
  localparam logic [31:0] I4  = 32'hA444_4444;
  localparam logic [31:0] I5  = 32'hA555_5555;
  localparam logic [31:0] I6  = 32'hA666_6666;

  always #5 clk = ~clk;

  // PC register on the other side of the interface.
  always @(posedge clk or posedge rst) begin
    if (rst)           pc_reg <= '0;
    else if (pc_wr_en) pc_reg <= pc_next;
  end

  fetch_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_clk_en      (clk_en),
    .i_pc          (pc_reg),
    .o_pc_next     (pc_next),
    .o_pc_wr_en    (pc_wr_en),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_rdata  (imem_rdata),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_if_valid    (if_valid),
    .o_if_pc       (if_pc),
    .o_if_instr    (if_instr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_req", {31'b0, imem_req}, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", {31'b0, if_valid}, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_instr", if_instr, NOP);
    check("rst_wr_en", {31'b0, pc_wr_en}, 0);
    check("rst_pc_next", pc_next, 0);
    tick; rst = 1'b0; #1;
    check("idle_wr_en", {31'b0, pc_wr_en}, 0);
    tick;                                 // ISSUE
    check("issue_req", {31'b0, imem_req}, 0);
    tick;                                 // REQ @0

    // Sequential fetch, zero-wait memory
    imem_ack = 1'b1; imem_rdata = I0; #1;
    check("seq0_req", {31'b0, imem_req}, 1);
    check("seq0_addr", imem_addr, 32'h0);
    check("seq0_wr_en", {31'b0, pc_wr_en}, 1);
    check("seq0_pc_next", pc_next, 32'h4);
    tick; imem_ack = 1'b0; #1;            // ISSUE, slot loaded
    check("seq0_valid", {31'b0, if_valid}, 1);
    check("seq0_if_pc", if_pc, 32'h0);
    check("seq0_instr", if_instr, I0);
    check("seq0_idle_wr", {31'b0, pc_wr_en}, 0);
    tick;                                 // REQ @4, slot consumed
    check("seq1_valid_clr", {31'b0, if_valid}, 0);
    imem_ack = 1'b1; imem_rdata = I1; #1;
    check("seq1_addr", imem_addr, 32'h4);
    check("seq1_pc_next", pc_next, 32'h8);
    tick; imem_ack = 1'b0; #1;
    check("seq1_if_pc", if_pc, 32'h4);
    check("seq1_instr", if_instr, I1);
    tick;                                 // REQ @8
    imem_ack = 1'b1; imem_rdata = I2; #1;
    check("seq2_addr", imem_addr, 32'h8);
    check("seq2_pc_next", pc_next, 32'hC);
    tick; imem_ack = 1'b0;

    // Stall four cycles while an instruction is held
    stall = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", {31'b0, if_valid}, 1);
      check("stall_instr", if_instr, I2);
      check("stall_no_req", {31'b0, imem_req}, 0);
      tick;
    end
    stall = 1'b0; #1;
    check("stall_rel_valid", {31'b0, if_valid}, 1);
    tick;                                 // REQ @12

    // Three wait cycles: request held stable for four cycles
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 3); imem_rdata = I3; #1;
      check("wait_req", {31'b0, imem_req}, 1);
      check("wait_addr", imem_addr, 32'hC);
      check("wait_wr_en", {31'b0, pc_wr_en}, (i == 3) ? 32'd1 : 32'd0);
      tick;
    end
    imem_ack = 1'b0; #1;
    check("wait_valid", {31'b0, if_valid}, 1);
    check("wait_if_pc", if_pc, 32'hC);
    check("wait_instr", if_instr, I3);
    tick;                                 // REQ @16

    // Redirect during REQ with two wait cycles: DROP then refetch at 0x100
    check("drop_pre_addr", imem_addr, 32'h10);
    tick;
    redirect = 1'b1; redirect_pc = 32'h100; #1;
    check("drop_wr_en", {31'b0, pc_wr_en}, 1);
    check("drop_pc_next", pc_next, 32'h100);
    tick; redirect = 1'b0; #1;            // DROP
    check("drop_req_held", {31'b0, imem_req}, 1);
    check("drop_addr_held", imem_addr, 32'h10);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    check("drop_ack_wr_en", {31'b0, pc_wr_en}, 0);
    tick; imem_ack = 1'b0; #1;            // ISSUE
    check("drop_valid", {31'b0, if_valid}, 0);
    check("drop_instr", if_instr, I3);
    check("drop_req_clr", {31'b0, imem_req}, 0);
    tick;                                 // REQ @0x100
    check("redir_addr", imem_addr, 32'h100);

    // Redirect coincident with ack
    imem_ack = 1'b1; imem_rdata = I4; redirect = 1'b1; redirect_pc = 32'h200; #1;
    check("coinc_wr_en", {31'b0, pc_wr_en}, 1);
    check("coinc_pc_next", pc_next, 32'h200);
    tick; imem_ack = 1'b0; redirect = 1'b0; #1;
    check("coinc_valid", {31'b0, if_valid}, 0);
    check("coinc_req", {31'b0, imem_req}, 0);
    tick;                                 // REQ @0x200
    check("coinc_next_addr", imem_addr, 32'h200);
    imem_ack = 1'b1; imem_rdata = I4; #1;
    tick; imem_ack = 1'b0; #1;
    check("fetch200_valid", {31'b0, if_valid}, 1);

    // Redirect in ISSUE while stalled flushes the slot
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    check("flush_wr_en", {31'b0, pc_wr_en}, 1);
    tick; redirect = 1'b0; stall = 1'b0; #1;
    check("flush_valid", {31'b0, if_valid}, 0);
    check("flush_no_req", {31'b0, imem_req}, 0);
    tick;                                 // REQ @0xFFFFFFFC

    // PC wrap
    imem_ack = 1'b1; imem_rdata = I5; #1;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_pc_next", pc_next, 32'h0);
    tick; imem_ack = 1'b0; #1;
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

    // Clock enable low freezes everything
    clk_en = 1'b0; #1;
    check("cen_wr_en", {31'b0, pc_wr_en}, 0);
    tick; tick; tick;
    check("cen_valid", {31'b0, if_valid}, 1);
    check("cen_instr", if_instr, I5);
    check("cen_req", {31'b0, imem_req}, 0);
    clk_en = 1'b1;
    tick;                                 // REQ @0
    clk_en = 1'b0; imem_ack = 1'b1; imem_rdata = I6; redirect = 1'b1; #1;
    check("cen_ack_ignored", {31'b0, pc_wr_en}, 0);
    tick;
    check("cen_req_frozen", {31'b0, imem_req}, 1);
    check("cen_valid_frozen", {31'b0, if_valid}, 0);
    clk_en = 1'b1; redirect = 1'b0; #1;
    check("cen_resume_pc_next", pc_next, 32'h4);
    tick; imem_ack = 1'b0;
    tick;                                 // REQ @4

    // Asynchronous reset mid-REQ
    check("pre_rst_addr", imem_addr, 32'h4);
    #2 rst = 1'b1; #1;
    check("mrst_req", {31'b0, imem_req}, 0);
    check("mrst_addr", imem_addr, 0);
    check("mrst_valid", {31'b0, if_valid}, 0);
    check("mrst_instr", if_instr, NOP);
    check("mrst_wr_en", {31'b0, pc_wr_en}, 0);
    check("mrst_pc_next", pc_next, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
